// File: rtl/mpu_sequencer_if.sv
// ----------------------------------------------------------------------------
// mpu_sequencer_if
//
// Bundle of every non-clock/reset signal of the MPU instruction sequencer.
//
// Handshake semantics:
//   fetch : fetch_req (valid) is held high with fetch_addr stable until
//           fetch_ack (ready) is seen high on a rising edge. The ack may
//           arrive in the first cycle fetch_req is high.
//   exec  : exec_en is a one-cycle strobe. ip_en/ip_incr/ip_load/ip_data,
//           user_irq and data are sampled in that same cycle.
//   irq   : irq (valid) is a level held with irq_data stable until irq_ack
//           (ready) is seen high on a rising edge. irq drops the next cycle.
//   Acks that arrive while their request is low are ignored.
//
// Modports:
//   master : the sequencer (drives fetch/exec/irq/status)
//   slave  : host + fetch unit + execution unit
// ----------------------------------------------------------------------------
interface mpu_sequencer_if;
    // host control
    logic        en;
    logic [15:0] start_ip;
    // fetch handshake
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    // execute strobe and IP update from the execution unit
    logic        exec_en;
    logic        ip_en;
    logic [15:0] ip_incr;
    logic        ip_load;
    logic [15:0] ip_data;
    // user interrupt
    logic        user_irq;
    logic [63:0] data;
    logic        irq;
    logic [63:0] irq_data;
    logic        irq_ack;
    // status
    logic [15:0] ip;
    logic        busy;
    logic        halted;
    logic        error;
    // debug view of the FSM state (0 IDLE, 1 FETCH, 2 EXEC, 3 IRQ)
    logic [1:0]  seq_state;

    modport master (
        input  en, start_ip, fetch_ack, ip_en, ip_incr, ip_load, ip_data,
               user_irq, data, irq_ack,
        output fetch_req, fetch_addr, exec_en, irq, irq_data, ip, busy,
               halted, error, seq_state
    );

    modport slave (
        output en, start_ip, fetch_ack, ip_en, ip_incr, ip_load, ip_data,
               user_irq, data, irq_ack,
        input  fetch_req, fetch_addr, exec_en, irq, irq_data, ip, busy,
               halted, error, seq_state
    );
endinterface

// File: rtl/mpu_sequencer.sv
// ----------------------------------------------------------------------------
// mpu_sequencer
//
// Instruction sequencer for the MPU core. Owns the 16-bit instruction
// pointer and walks the core through FETCH and EXEC one instruction at a
// time, applies the execution unit's IP update, stalls in IRQ while a user
// interrupt is pending at the host, and aborts a fetch that is not acked
// within TIMEOUT cycles (sticky error).
//
// Parameters:
//   TIMEOUT   : FETCH cycles without fetch_ack before abort (1..65535)
//
// Ports:
//   sys_clk   : core clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : mpu_sequencer_if.master (host control, fetch handshake,
//               execute strobe / IP update, interrupt handshake, status,
//               debug state)
//
// Every output is a flop; fetch_addr and ip are both the IP register.
// ----------------------------------------------------------------------------
module mpu_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    mpu_sequencer_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_IRQ   = 2'd3
    } state_t;

    // Counter value seen in the TIMEOUT-th FETCH cycle (counter starts at 0).
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] ip_q;
    logic [63:0] irq_data_q;
    logic [15:0] cnt_q;
    logic        halt_pend_q;

    // Registered output decodes, updated together with every state change.
    logic        fetch_req_q;
    logic        exec_en_q;
    logic        irq_q;
    logic        busy_q;
    logic        halted_q;
    logic        error_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            ip_q        <= 16'h0000;
            irq_data_q  <= 64'h0;
            cnt_q       <= 16'h0000;
            halt_pend_q <= 1'b0;
            fetch_req_q <= 1'b0;
            exec_en_q   <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // halted is a single-cycle pulse
            halted_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.en) begin
                        ip_q        <= bus.start_ip;
                        error_q     <= 1'b0;
                        cnt_q       <= 16'h0000;
                        state       <= ST_FETCH;
                        fetch_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (!bus.en) begin
                        // host stop abandons the fetch without flagging error
                        state       <= ST_IDLE;
                        fetch_req_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cnt_q       <= 16'h0000;
                    end else if (bus.fetch_ack) begin
                        state       <= ST_EXEC;
                        fetch_req_q <= 1'b0;
                        exec_en_q   <= 1'b1;
                        cnt_q       <= 16'h0000;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        error_q     <= 1'b1;
                        state       <= ST_IDLE;
                        fetch_req_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cnt_q       <= 16'h0000;
                    end else begin
                        cnt_q <= cnt_q + 16'h0001;
                    end
                end

                ST_EXEC: begin
                    exec_en_q <= 1'b0;

                    // Jump wins over increment; the add wraps at 16 bits.
                    if (bus.ip_en) begin
                        if (bus.ip_load) begin
                            ip_q <= bus.ip_data;
                        end else begin
                            ip_q <= ip_q + bus.ip_incr;
                        end
                    end

                    if (bus.user_irq) begin
                        // A halting instruction that also raises an irq
                        // halts only once the host has acknowledged.
                        irq_data_q  <= bus.data;
                        halt_pend_q <= ~bus.ip_en;
                        state       <= ST_IRQ;
                        irq_q       <= 1'b1;
                    end else if (!bus.ip_en) begin
                        halted_q <= 1'b1;
                        state    <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end else if (!bus.en) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state       <= ST_FETCH;
                        fetch_req_q <= 1'b1;
                        cnt_q       <= 16'h0000;
                    end
                end

                ST_IRQ: begin
                    // Only the host ack leaves IRQ; en=0 alone is ignored.
                    if (bus.irq_ack) begin
                        irq_q       <= 1'b0;
                        halt_pend_q <= 1'b0;
                        if (halt_pend_q) begin
                            halted_q <= 1'b1;
                            state    <= ST_IDLE;
                            busy_q   <= 1'b0;
                        end else if (!bus.en) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state       <= ST_FETCH;
                            fetch_req_q <= 1'b1;
                            cnt_q       <= 16'h0000;
                        end
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    fetch_req_q <= 1'b0;
                    exec_en_q   <= 1'b0;
                    irq_q       <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_req  = fetch_req_q;
    assign bus.fetch_addr = ip_q;
    assign bus.exec_en    = exec_en_q;
    assign bus.irq        = irq_q;
    assign bus.irq_data   = irq_data_q;
    assign bus.ip         = ip_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.error      = error_q;
    assign bus.seq_state  = state;

endmodule

// File: doc/mpu_sequencer.md
# mpu_sequencer

Instruction sequencer for the MPU core. Owns the 16-bit instruction pointer and steps the core through fetch and execute, one instruction at a time. It applies the execution unit's IP update (`ip_en`, `ip_incr`, `ip_load`, `ip_data`). It holds the core stalled while a user interrupt raised by the execution unit is pending at the host, and provides run/stop control, a fetch timeout and status toward the host CSR interface.

## Interface
- `TIMEOUT`, default 255: number of cycles in FETCH without `fetch_ack` before the error abort; legal range 1..65535.
- `sys_clk` in 1: core clock; all state changes on its rising edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `en` in 1: host run enable (level).
- `start_ip` in 16: IP loaded when leaving IDLE.
- `fetch_req` out 1: instruction fetch request, held until acked.
- `fetch_addr` out 16: fetch address, equal to `ip`.
- `fetch_ack` in 1: instruction available and decoded; operands are valid to the execution unit.
- `exec_en` out 1: one-cycle execute strobe to the execution unit.
- `ip_en` in 1: from the execution unit; 1 = advance IP, 0 = halt after this instruction.
- `ip_incr` in 16: from the execution unit; IP increment.
- `ip_load` in 1: from the execution unit; 1 = jump.
- `ip_data` in 16: from the execution unit; jump target.
- `user_irq` in 1: from the execution unit; user interrupt request.
- `data` in 64: from the execution unit; interrupt payload.
- `irq` out 1: interrupt to host, level.
- `irq_data` out 64: latched payload.
- `irq_ack` in 1: host acknowledge.
- `ip` out 16: current instruction pointer.
- `busy` out 1: 1 in every state except IDLE.
- `halted` out 1: one-cycle pulse on a halt return to IDLE.
- `error` out 1: sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, EXEC, IRQ. Reset state is IDLE.
- Reset values: `ip`=0, `irq_data`=0, timeout counter=0, `halt_pend`=0. All outputs are 0.
- IDLE:
  - If `en`=1: `ip`<=`start_ip`, `error`<=0, counter<=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - `fetch_req`=1, `fetch_addr`=`ip`.
  - Priority 1: `en`=0 -> IDLE. Fetch is abandoned, no error.
  - Priority 2: `fetch_ack`=1 -> EXEC, counter<=0.
  - Priority 3: counter reaches `TIMEOUT`-1 with no ack -> `error`<=1, IDLE.
  - Otherwise counter increments.
- EXEC:
  - `exec_en`=1 for exactly one cycle. Execution outputs are combinational and are sampled in this same cycle.
  - IP update:
    - `ip_en`=1 and `ip_load`=1: `ip`<=`ip_data`. Load has priority over increment.
    - `ip_en`=1 and `ip_load`=0: `ip`<=`ip`+`ip_incr` modulo 2^16 (0xFFFE + 4 = 0x0002, no flag).
    - `ip_en`=0: `ip` unchanged.
  - Next state:
    - `user_irq`=1 -> `irq_data`<=`data`, `halt_pend`<=~`ip_en`, go to IRQ.
    - Else `ip_en`=0 -> pulse `halted`, go to IDLE.
    - Else `en`=0 -> IDLE.
    - Else FETCH.
- IRQ:
  - `irq`=1 and `irq_data` stable until acknowledged.
  - On `irq_ack`=1:
    - If `halt_pend`: pulse `halted`, go to IDLE.
    - Else if `en`=0: go to IDLE.
    - Else go to FETCH.
    - `halt_pend`<=0.
  - `en`=0 alone does not leave IRQ; the host must acknowledge.
- `irq_ack` outside IRQ and `fetch_ack` outside FETCH are ignored.
- Reset asserted mid-operation returns to IDLE immediately. `irq`, `fetch_req` and `exec_en` drop asynchronously.

## Timing
- `fetch_ack` is accepted in the same cycle `fetch_req` first rises. Minimum throughput is 2 cycles per instruction (FETCH, EXEC).
- New `ip` is visible on `fetch_addr` in the cycle after EXEC.
- `irq` rises the cycle after EXEC and falls the cycle after the `irq_ack` sample.
- Timeout fires in the `TIMEOUT`-th FETCH cycle without ack. `error` is visible the next cycle, with `busy`=0.
- All outputs are registered state decodes. `fetch_addr` = `ip` register; no combinational paths from inputs to outputs.

## Test plan
- Straight-line run: `start_ip`=0x0010, `en`=1, `fetch_ack` tied 1, `ip_en`=1, `ip_incr`=4, 3 instructions.
  - Required: `fetch_addr` = 0x0010, 0x0014, 0x0018.
  - Required: `exec_en` pulses every 2nd cycle.
- Jump and wrap:
  - At `ip`=0x0020 drive `ip_load`=1, `ip_data`=0xFFFE -> next `fetch_addr`=0xFFFE.
  - Then `ip_incr`=4 -> next `fetch_addr`=0x0002.
- Interrupt:
  - `user_irq`=1, `data`=0xDEADBEEF_00000001 at EXEC -> `irq`=1 with that `irq_data`.
  - Core stays stalled for 10 cycles with no fetch.
  - `irq_ack` -> FETCH at the updated `ip`.
- IRQ with halt: `user_irq`=1 with `ip_en`=0 -> IRQ, then after ack `halted` pulses and `busy`=0.
- Timeout: `TIMEOUT`=8, `fetch_ack` held 0 -> `error`=1 and IDLE after 8 FETCH cycles; re-assert `en` -> `error` clears.
- Abort/reset:
  - `en`=0 during FETCH -> IDLE with `error`=0.
  - `sys_rst_n` pulsed low in IRQ -> `irq`=0 immediately and `ip`=0.
